// File: rtl/mem_pkg.sv
// Shared line-memory definitions: line geometry and the lane-to-bit-slice mapping
// used by the data memory and every block that builds or consumes line data.
package mem_pkg;
  localparam int LINE_W  = 512;
  localparam int LANES   = 32;
  localparam int LADDR_W = 11;
  localparam int HW_W    = 16;
  localparam int LANE_W  = $clog2(LANES);

  // MSB of lane i; pair with [lane_range(i) -: HW_W]. Lane 0 sits in the top bits.
  function automatic int lane_range(input int i);
    return LINE_W - 1 - HW_W * i;
  endfunction
endpackage

// File: rtl/wcb_entry.sv
// One write-combining line register: lane merge, lane mask and saturating age.
// Allocation wins over clear so a full buffer can recycle the draining slot in one cycle.
module wcb_entry
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AGE_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc,
  input  logic               merge,
  input  logic               clear,
  input  logic [LADDR_W-1:0] st_line,
  input  logic [LANE_W-1:0]  st_lane,
  input  logic [HW_W-1:0]    st_data,
  output logic               valid,
  output logic [LADDR_W-1:0] line,
  output logic [LINE_W-1:0]  data,
  output logic [LANES-1:0]   lmask,
  output logic [AGE_W-1:0]   age
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      lmask <= '0;
      age   <= '0;
    end else if (alloc) begin
      valid <= 1'b1;
      lmask <= LANES'(1) << st_lane;
      age   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      lmask <= '0;
      age   <= '0;
    end else if (merge) begin
      lmask[st_lane] <= 1'b1;
      age            <= '0;
    end else if (valid && age < AGE_MAX) begin
      age <= age + 1'b1;
    end
  end

  // Line and lane data carry no reset; lmask/valid qualify them.
  always_ff @(posedge clk) begin
    if (alloc) begin
      line <= st_line;
      data <= '0;
      data[lane_range(int'(st_lane)) -: HW_W] <= st_data;
    end else if (merge) begin
      data[lane_range(int'(st_lane)) -: HW_W] <= st_data;
    end
  end

endmodule

// File: rtl/store_coalesce_buf.sv
// Write-combining buffer merging 16-bit stores into 64-byte lines, retired in FIFO order
// as masked line writes. Define STORE_FWD_EN to enable load forwarding of buffered lanes.
module store_coalesce_buf
  import mem_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [15:0]        st_addr,
  input  logic [15:0]        st_data,
  input  logic               flush_req,
  output logic               flush_done,
  input  logic [LADDR_W-1:0] ld_addr,
  output logic               ld_hazard,
  output logic [LINE_W-1:0]  ld_fwd_data,
  output logic [LANES-1:0]   ld_fwd_mask,
  output logic               wen64,
  output logic [LADDR_W-1:0] waddr64,
  output logic [LINE_W-1:0]  wdata64,
  output logic [LANES-1:0]   mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic               e_valid [DEPTH];
  logic [LADDR_W-1:0] e_line  [DEPTH];
  logic [LINE_W-1:0]  e_data  [DEPTH];
  logic [LANES-1:0]   e_lmask [DEPTH];
  logic [AGE_W-1:0]   e_age   [DEPTH];
  logic [DEPTH-1:0]   e_alloc, e_merge, e_clear, hit;

  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  logic [LADDR_W-1:0] st_line;
  logic [LANE_W-1:0]  st_lane;
  logic               full, timeout_hit, drain_fire, match, accept, do_alloc;

  assign st_line = st_addr[15:5];
  assign st_lane = st_addr[4:0];
  assign full    = (count == FULL_CNT);

  generate
    if (TIMEOUT > 0) begin : g_tmo
      assign timeout_hit = (e_age[head] >= AGE_W'(TIMEOUT));
    end else begin : g_no_tmo
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign drain_fire = e_valid[head] && ((&e_lmask[head]) || flush_req || full || timeout_hit);

  // The head leaving this cycle is excluded so a same-line store lands in a fresh entry.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++)
      hit[i] = e_valid[i] && (e_line[i] == st_line) && !(drain_fire && head == PTR_W'(i));
  end

  assign match    = |hit;
  assign st_ready = match | ~full | drain_fire;
  assign accept   = st_valid & st_ready;
  assign do_alloc = accept & ~match;

  always_comb begin
    e_alloc = '0;
    e_merge = '0;
    e_clear = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e_merge[i] = accept & hit[i];
      e_alloc[i] = do_alloc && (tail == PTR_W'(i));
      e_clear[i] = drain_fire && (head == PTR_W'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    wcb_entry #(.TIMEOUT(TIMEOUT), .AGE_W(AGE_W)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .alloc   (e_alloc[g]),
      .merge   (e_merge[g]),
      .clear   (e_clear[g]),
      .st_line (st_line),
      .st_lane (st_lane),
      .st_data (st_data),
      .valid   (e_valid[g]),
      .line    (e_line[g]),
      .data    (e_data[g]),
      .lmask   (e_lmask[g]),
      .age     (e_age[g])
    );
  end

  // Output register stage: FIFO pointers and the masked line-write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wen64   <= 1'b0;
      waddr64 <= '0;
      wdata64 <= '0;
      mask    <= '0;
    end else begin
      if (do_alloc)   tail <= tail + 1'b1;
      if (drain_fire) head <= head + 1'b1;
      count <= count + CNT_W'(do_alloc) - CNT_W'(drain_fire);
      wen64 <= drain_fire;
      if (drain_fire) begin
        waddr64 <= e_line[head];
        wdata64 <= e_data[head];
        mask    <= e_lmask[head];
      end
    end
  end

  always_comb begin
    ld_hazard = wen64 && (waddr64 == ld_addr);
    for (int i = 0; i < DEPTH; i++)
      if (e_valid[i] && e_line[i] == ld_addr) ld_hazard = 1'b1;
  end

  assign flush_done = (count == '0) && !wen64;

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Oldest source first (in-flight write, then head..tail) so younger lanes overwrite.
  always_comb begin
    ld_fwd_data = '0;
    ld_fwd_mask = '0;
    fwd_idx     = '0;
    if (wen64 && waddr64 == ld_addr) begin
      ld_fwd_mask = mask;
      for (int j = 0; j < LANES; j++)
        if (mask[j]) ld_fwd_data[lane_range(j) -: HW_W] = wdata64[lane_range(j) -: HW_W];
    end
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PTR_W'(k);
      if (e_valid[fwd_idx] && e_line[fwd_idx] == ld_addr) begin
        ld_fwd_mask = ld_fwd_mask | e_lmask[fwd_idx];
        for (int j = 0; j < LANES; j++)
          if (e_lmask[fwd_idx][j])
            ld_fwd_data[lane_range(j) -: HW_W] = e_data[fwd_idx][lane_range(j) -: HW_W];
      end
    end
  end
`else
  assign ld_fwd_data = '0;
  assign ld_fwd_mask = '0;
`endif

endmodule
